bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between NUM_REQ requesters, such as merge lanes or a loader and a drain unit.
- Arbitrates with a round-robin valid/ready handshake and drives the port's we/addr/din.
- Tracks the RAM's 1-cycle read latency and returns the read response to the requester that issued it.
- Sits between the merge datapath and the RAM port; the other RAM port is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- BURST_LEN, 4, max consecutive grants to one requester (used only with ARB_BURST_EN).

Ports:
- clk  in  1  single clock; the RAM port clock is tied to this clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens when valid & ready.
- rsp_valid  out  NUM_REQ  one-hot read response strobe.
- rsp_data  out  DATA_WIDTH  read data, valid only while the matching rsp_valid bit is set.
- bram_we  out  1  to the RAM port write enable.
- bram_addr  out  ADDR_WIDTH  to the RAM port address.
- bram_din  out  DATA_WIDTH  to the RAM port data in.
- bram_dout  in  DATA_WIDTH  from the RAM port data out (registered inside the RAM).
- grant_idx  out  clog2(NUM_REQ)  index of the current grant; holds its last value when idle.
- busy  out  1  high when any req_valid is set or a response is pending.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - rr_ptr=0, rsp_valid=0, grant_idx=0, burst_cnt=0.
  - While rst=1: req_ready=0 and bram_we=0, regardless of req_valid.
- Grant (combinational, one per cycle):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready is the one-hot of the winner; it is 0 when no req_valid is set.
- Port drive:
  - bram_addr and bram_din are the winner's fields.
  - bram_we = winner's req_we & grant.
  - When idle: bram_we=0, bram_addr=0, bram_din=0.
- Pointer update:
  - On each accepted transfer, rr_ptr <= (winner+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Read response:
  - A read accepted at edge T sets rsp_valid[winner] at edge T; it is seen high for exactly the following cycle.
  - rsp_data = bram_dout (pass-through), valid in that same cycle.
  - Accepted writes produce no rsp_valid.
  - Back-to-back reads from different requesters give back-to-back one-hot rsp_valid in order, with no bubbles.
- Throughput: one transfer per cycle; no dead cycles between grants.
- Simultaneous events: a requester may issue a new request in the same cycle its previous response is returned.
- Write followed by a read to the same address from another requester on the next cycle returns the new data (the RAM has written it by then).
- Reset mid-operation: a pending response is dropped (rsp_valid cleared) and the pointer returns to 0.
- Handshake rule: requesters hold req_valid and their fields stable until ready. The arbiter does not check this; a requester that drops valid before ready is simply skipped.
- grant_idx registers the winner's index on each accepted transfer.

Optional Feature:
- Macro ARB_BURST_EN.
- Defined:
  - After a grant to requester i, i keeps priority while req_valid[i] stays high and burst_cnt < BURST_LEN-1.
  - burst_cnt increments per consecutive grant to i.
  - When i drops valid or burst_cnt reaches BURST_LEN-1: rr_ptr <= i+1 and burst_cnt <= 0.
- Undefined: strict per-transfer rotation as above; burst_cnt and BURST_LEN are unused.

Test Plan:
- Reset, then requester 2 reads addr 0x005 with RAM preloaded 0x005=0xBEEF -> req_ready=4'b0100 in the same cycle; next cycle rsp_valid=4'b0100, rsp_data=0xBEEF.
- All four requesters hold valid reads continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid follows one cycle later with each matching address's data.
- Requester 1 writes 0x0A5A to 0x010, then requester 3 reads 0x010 on the next cycle -> rsp_valid=4'b1000, rsp_data=0x0A5A; no rsp_valid for the write.
- Requesters 0 and 3 valid, rr_ptr=1 -> 3 granted first, then 0; rr_ptr ends at 1.
- Read accepted, then rst asserted on the next edge -> rsp_valid=0, req_ready=0, bram_we=0 during reset; grant restarts at requester 0.
- ARB_BURST_EN, BURST_LEN=4, requesters 0 and 1 always valid -> grant pattern 0,0,0,0,1,1,1,1,0…; without the macro the pattern is 0,1,0,1….

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters; routes the 1-cycle read response back.
// Optional ARB_BURST_EN: a granted requester keeps priority for up to BURST_LEN consecutive transfers.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_din,
  input  logic [DATA_WIDTH-1:0]            bram_dout,
  output logic [$clog2(NUM_REQ)-1:0]       grant_idx,
  output logic                             busy
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1) begin : g_param_check
    $error("bram_port_arbiter: NUM_REQ must be 2..8 and BURST_LEN >= 1");
  end

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + IW'(1);
  endfunction

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      rr_nxt;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               xfer;
  logic               rd_xfer;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_vld_p1;

  // Stage p0: rotating priority search starting at rr_ptr
  always_comb begin
    int            c;
    logic [IW-1:0] ci;
    win_found = 1'b0;
    win_idx   = rr_ptr;
    c         = 0;
    ci        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IW'(c);
      if (!win_found && req_valid[ci]) begin
        win_found = 1'b1;
        win_idx   = ci;
      end
    end
  end

  always_comb begin
    xfer    = win_found & ~rst;
    rd_xfer = xfer & ~req_we[win_idx];
    grant   = '0;
    if (xfer) grant[win_idx] = 1'b1;
  end

  always_comb begin
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (xfer) begin
      bram_we   = req_we[win_idx];
      bram_addr = addr_arr[win_idx];
      bram_din  = wdata_arr[win_idx];
    end
  end

  assign req_ready = grant;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN) + 1;

  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_cnt_nxt;
  logic [CW-1:0] cnt_base;

  // A grant that is not to the priority holder starts a fresh burst.
  always_comb begin
    rr_nxt        = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    cnt_base      = '0;
    if (xfer) begin
      cnt_base = (win_idx == rr_ptr) ? burst_cnt : '0;
      if (int'(cnt_base) < BURST_LEN - 1) begin
        rr_nxt        = win_idx;
        burst_cnt_nxt = cnt_base + CW'(1);
      end else begin
        rr_nxt        = wrap_inc(win_idx);
        burst_cnt_nxt = '0;
      end
    end else if (burst_cnt != '0 && !req_valid[rr_ptr]) begin
      rr_nxt        = wrap_inc(rr_ptr);
      burst_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) burst_cnt <= '0;
    else     burst_cnt <= burst_cnt_nxt;
  end
`else
  always_comb rr_nxt = xfer ? wrap_inc(win_idx) : rr_ptr;
`endif

  // Stage p1: read response strobe, aligned with the RAM's registered dout
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_idx  <= '0;
      rsp_vld_p1 <= '0;
    end else begin
      rr_ptr     <= rr_nxt;
      rsp_vld_p1 <= rd_xfer ? grant : '0;
      if (xfer) grant_idx <= win_idx;
    end
  end

  assign rsp_valid = rsp_vld_p1;
  assign rsp_data  = bram_dout;
  assign busy      = (|req_valid) | (|rsp_vld_p1);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: RAM model, grant model, and a response scoreboard drained by a monitor.
module tb_bram_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, bram_din, bram_dout;
  logic [AW-1:0]   bram_addr;
  logic            bram_we, busy;
  logic [1:0]      grant_idx;

  logic [AW-1:0] a  [N];
  logic [DW-1:0] wd [N];

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = wd[i];
    end
  end

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .grant_idx(grant_idx), .busy(busy)
  );

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [N-1:0] vld;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  // Scoreboard drain: every cycle the strobe must match the entry due now (or be zero).
  always @(negedge clk) begin
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    if (mon_en) begin
      ev = '0;
      ed = '0;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = q[0].vld;
        ed = q[0].data;
        void'(q.pop_front());
      end
      n_tests++;
      if (rsp_valid !== ev) begin
        n_fail++;
        $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, ev);
      end else if (ev != '0) begin
        n_tests++;
        if (rsp_data !== ed) begin
          n_fail++;
          $display("FAIL rsp_data cyc=%0d: got %h expected %h", cyc, rsp_data, ed);
        end
      end
    end
  end

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic int model_win();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Predict the effect of the coming edge, then step one cycle.
  task automatic advance(input int w);
    rsp_t e;
    int   base;
    if (w >= 0) begin
      if (req_we[w]) ref_mem[a[w]] = wd[w];
      else begin
        e.due  = cyc + 1;
        e.vld  = onehot(w);
        e.data = ref_mem[a[w]];
        q.push_back(e);
      end
    end
`ifdef ARB_BURST_EN
    if (w >= 0) begin
      base = (w == m_ptr) ? m_cnt : 0;
      if (base < BL - 1) begin m_ptr = w; m_cnt = base + 1; end
      else begin m_ptr = (w + 1) % N; m_cnt = 0; end
    end else if (m_cnt != 0 && !req_valid[m_ptr]) begin
      m_ptr = (m_ptr + 1) % N;
      m_cnt = 0;
    end
`else
    base = 0;
    if (w >= 0) m_ptr = (w + base + 1) % N;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    req_valid = '0;
    rst = 1'b1;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mem[addr]     = data;
    ref_mem[addr] = data;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin a[i] = AW'(i + 1); wd[i] = 16'h5555; end
    req_valid = '1;
    req_we    = '1;
    rst       = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_tests++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_bram_we: got %b expected 0", bram_we); end
    n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    n_tests++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    req_valid = '0;
    req_we    = '0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    preload(10'h005, 16'hBEEF);
    a[2] = 10'h005;
    req_we = '0;
    req_valid = 4'b0100;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    n_tests++; if (bram_addr !== 10'h005) begin n_fail++; $display("FAIL single_addr: got %h expected 005", bram_addr); end
    advance(2);
    req_valid = '0;
    #1;
    n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
    n_tests++; if (rsp_data !== 16'hBEEF) begin n_fail++; $display("FAIL single_rsp_data: got %h expected beef", rsp_data); end
    n_tests++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL single_grant_idx: got %0d expected 2", grant_idx); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    advance(-1);
  endtask

  task automatic test_back_to_back();
`ifdef ARB_BURST_EN
    int exp_seq[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    rst_pulse();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(10'h020 + i);
      preload(a[i], DW'(16'h1100 + 16'(i)));
    end
    req_we = '0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_tests++;
      if (req_ready !== onehot(exp_seq[k])) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, onehot(exp_seq[k]));
      end
      advance(exp_seq[k]);
      n_tests++;
      if (grant_idx !== 2'(exp_seq[k])) begin
        n_fail++; $display("FAIL rr_grant_idx[%0d]: got %0d expected %0d", k, grant_idx, exp_seq[k]);
      end
    end
    req_valid = '0;
    advance(-1);
  endtask

  task automatic test_write_read();
    preload(10'h010, 16'h1234);
    req_valid = 4'b0010;
    req_we    = 4'b0010;
    a[1] = 10'h010;
    wd[1] = 16'h0A5A;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wr_ready: got %b expected 0010", req_ready); end
    n_tests++; if ({bram_we, bram_addr, bram_din} !== {1'b1, 10'h010, 16'h0A5A}) begin
      n_fail++; $display("FAIL wr_port: got we=%b addr=%h din=%h expected 1 010 0a5a", bram_we, bram_addr, bram_din);
    end
    advance(1);
    req_valid = 4'b1000;
    req_we    = 4'b0000;
    a[3] = 10'h010;
    #1;
    n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_no_rsp: got %b expected 0000", rsp_valid); end
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rd_ready: got %b expected 1000", req_ready); end
    advance(3);
    req_valid = '0;
    #1;
    n_tests++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 1000", rsp_valid); end
    n_tests++; if (rsp_data !== 16'h0A5A) begin n_fail++; $display("FAIL rd_rsp_data: got %h expected 0a5a", rsp_data); end
    advance(-1);
  endtask

  task automatic test_priority();
    int w1, w2, w3;
    rst_pulse();
    req_we = '0;
    a[0] = 10'h020;
    a[3] = 10'h023;
    req_valid = 4'b0001;
    advance(0);
    req_valid = 4'b1001;
`ifdef ARB_BURST_EN
    w1 = model_win();
`else
    w1 = 3;
`endif
    #1;
    n_tests++; if (req_ready !== onehot(w1)) begin n_fail++; $display("FAIL prio_first: got %b expected %b", req_ready, onehot(w1)); end
    advance(w1);
    req_valid[w1] = 1'b0;
`ifdef ARB_BURST_EN
    w2 = model_win();
`else
    w2 = 0;
`endif
    #1;
    n_tests++; if (req_ready !== onehot(w2)) begin n_fail++; $display("FAIL prio_second: got %b expected %b", req_ready, onehot(w2)); end
    advance(w2);
    req_valid = '1;
`ifdef ARB_BURST_EN
    w3 = model_win();
`else
    w3 = 1;
`endif
    #1;
    n_tests++; if (req_ready !== onehot(w3)) begin n_fail++; $display("FAIL prio_ptr_end: got %b expected %b", req_ready, onehot(w3)); end
    req_valid = '0;
    #1;
    advance(-1);
  endtask

  task automatic test_reset_mid();
    req_we = '0;
    a[2] = 10'h005;
    req_valid = 4'b0100;
    #1;
    n_tests++; if (req_ready !== onehot(model_win())) begin n_fail++; $display("FAIL mid_ready: got %b expected %b", req_ready, onehot(model_win())); end
    advance(model_win());
    rst = 1'b1;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    req_valid = 4'b0001;
    req_we    = 4'b0001;
    a[0] = 10'h030;
    wd[0] = 16'hDEAD;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    n_tests++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we: got %b expected 0", bram_we); end
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rsp: got %b expected 0000", rsp_valid); end
    n_tests++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL mid_rst_gidx: got %0d expected 0", grant_idx); end
    rst = 1'b0;
    req_we = '0;
    for (int i = 0; i < N; i++) a[i] = AW'(10'h020 + i);
    req_valid = '1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_restart: got %b expected 0001", req_ready); end
    advance(0);
    req_valid = '0;
    advance(-1);
  endtask

  task automatic test_alternate();
`ifdef ARB_BURST_EN
    int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
    int exp_seq[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
    rst_pulse();
    req_we = '0;
    a[0] = 10'h020;
    a[1] = 10'h021;
    req_valid = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      #1;
      n_tests++;
      if (req_ready !== onehot(exp_seq[k])) begin
        n_fail++; $display("FAIL alt_ready[%0d]: got %b expected %b", k, req_ready, onehot(exp_seq[k]));
      end
      advance(exp_seq[k]);
    end
    req_valid = '0;
    advance(-1);
    advance(-1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin a[i] = '0; wd[i] = '0; end
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = DW'(i); ref_mem[i] = DW'(i); end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_read();
    test_priority();
    test_reset_mid();
    test_alternate();
    @(negedge clk);
    mon_en = 1'b0;
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
